// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: turns a 32-bit word access from the mem stage
// into one byte-wide RAM access per selected lane, then assembles the load word.
module mem_ctrl #(
    parameter int RAM_ADDR_W = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce_i,
    input  logic                  we_i,
    input  logic [31:0]           addr_i,
    input  logic [3:0]            sel_i,
    input  logic [31:0]           data_i,
    output logic [31:0]           data_o,
    output logic                  stall_req_o,
    output logic                  done_o,
    output logic [RAM_ADDR_W-1:0] ram_addr_o,
    output logic                  ram_re_o,
    output logic                  ram_we_o,
    output logic [7:0]            ram_wdata_o,
    input  logic [7:0]            ram_rdata_i
);

    typedef enum logic [1:0] {IDLE, XFER, FINISH} state_t;

    state_t                r_state;
    logic [RAM_ADDR_W-3:0] r_word;
    logic [3:0]            r_rem;
    logic [31:0]           r_wdata;
    logic                  r_we;
    logic [31:0]           r_rdata;
    logic                  r_pend;
    logic [1:0]            r_pend_idx;

    logic                  w_accept;
    logic [3:0]            w_src;
    logic [1:0]            w_idx;
    logic [3:0]            w_mask;
    logic [31:0]           w_data;

    function automatic logic [1:0] f_lowest(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    assign w_accept = (r_state == IDLE) && ce_i && (sel_i != 4'b0000);
    assign w_src    = (r_state == IDLE) ? sel_i : r_rem;
    assign w_idx    = f_lowest(w_src);
    assign w_mask   = w_src & ~(4'b0001 << w_idx);

    // The byte read in the previous cycle is merged combinationally so data_o is
    // already complete in the FINISH cycle, when done_o is high.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        w_data = r_rdata;
        if (r_pend)
            w_data[{r_pend_idx, 3'b000} +: 8] = ram_rdata_i;
    end

    assign data_o = w_data;

    always_comb begin
        stall_req_o = 1'b0;
        if (!rst) begin
            case (r_state)
                IDLE:    stall_req_o = w_accept;
                XFER:    stall_req_o = 1'b1;
                default: stall_req_o = 1'b0;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_word      <= '0;
            r_rem       <= '0;
            r_wdata     <= '0;
            r_we        <= 1'b0;
            r_rdata     <= '0;
            r_pend      <= 1'b0;
            r_pend_idx  <= '0;
            done_o      <= 1'b0;
            ram_addr_o  <= '0;
            ram_re_o    <= 1'b0;
            ram_we_o    <= 1'b0;
            ram_wdata_o <= '0;
        end else begin
            r_pend     <= ram_re_o;
            r_pend_idx <= ram_addr_o[1:0];
            r_rdata    <= w_accept ? 32'h0 : w_data;
            done_o     <= 1'b0;
            ram_re_o   <= 1'b0;
            ram_we_o   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_word      <= addr_i[RAM_ADDR_W-1:2];
                        r_we        <= we_i;
                        r_wdata     <= data_i;
                        r_rem       <= w_mask;
                        ram_addr_o  <= {addr_i[RAM_ADDR_W-1:2], w_idx};
                        ram_we_o    <= we_i;
                        ram_re_o    <= !we_i;
                        ram_wdata_o <= data_i[{w_idx, 3'b000} +: 8];
                        r_state     <= XFER;
                    end
                end
                XFER: begin
                    if (r_rem != 4'b0000) begin
                        r_rem       <= w_mask;
                        ram_addr_o  <= {r_word, w_idx};
                        ram_we_o    <= r_we;
                        ram_re_o    <= !r_we;
                        ram_wdata_o <= r_wdata[{w_idx, 3'b000} +: 8];
                    end else begin
                        done_o  <= 1'b1;
                        r_state <= FINISH;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte-wide synchronous RAM model.
module tb_mem_ctrl;

    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          rst;
    logic          ce, we;
    logic [31:0]   addr, wdata32;
    logic [3:0]    sel;
    logic [31:0]   d_out;
    logic          stall, done, r_re, r_we;
    logic [AW-1:0] r_addr;
    logic [7:0]    r_wd, r_rd;

    logic [7:0]    mem [0:(1<<AW)-1];

    logic [3:0]    tr_ctl  [0:15];
    logic [AW-1:0] tr_addr [0:15];
    logic [7:0]    tr_wd   [0:15];
    logic [31:0]   tr_data [0:15];

    int n_vec = 0;
    int n_err = 0;

    mem_ctrl #(.RAM_ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .ce_i(ce), .we_i(we), .addr_i(addr), .sel_i(sel),
        .data_i(wdata32), .data_o(d_out), .stall_req_o(stall), .done_o(done),
        .ram_addr_o(r_addr), .ram_re_o(r_re), .ram_we_o(r_we),
        .ram_wdata_o(r_wd), .ram_rdata_i(r_rd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (r_we) mem[r_addr] <= r_wd;
        if (r_re) r_rd <= mem[r_addr];
    end

    // Applies one request in cycle 0, then junk with ce low; records each cycle.
    task automatic issue(input logic t_we, input logic [31:0] t_addr,
                         input logic [3:0] t_sel, input logic [31:0] t_data, input int ncyc);
        ce = 1'b1; we = t_we; addr = t_addr; sel = t_sel; wdata32 = t_data;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            tr_ctl[c]  = {stall, done, r_re, r_we};
            tr_addr[c] = r_addr;
            tr_wd[c]   = r_wd;
            tr_data[c] = d_out;
            @(posedge clk); #1;
            if (c == 0) begin
                ce = 1'b0; we = ~t_we; addr = 32'hFFFF_FFFF; sel = 4'hF; wdata32 = 32'h5A5A_5A5A;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ce = 1'b1; we = 1'b0; addr = 32'h100; sel = 4'hF; wdata32 = '0;
        repeat (2) @(posedge clk);
        #2;
        n_vec++;
        if ({stall, done, r_re, r_we} !== 4'b0000) begin
            $display("FAIL reset_ctl got %b want 0000", {stall, done, r_re, r_we}); n_err++;
        end
        n_vec++;
        if ({r_addr, r_wd, d_out} !== '0) begin
            $display("FAIL reset_data got addr=%h wd=%h data=%h want zeros", r_addr, r_wd, d_out); n_err++;
        end
        ce = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_load_word();
        logic [3:0] e_ctl [0:6] = '{4'b1000, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b0100, 4'b0000};
        issue(1'b0, 32'h100, 4'b1111, 32'h0, 7);
        for (int c = 0; c < 7; c++) begin
            n_vec++;
            if (tr_ctl[c] !== e_ctl[c]) begin
                $display("FAIL load_word_ctl c%0d got %b want %b", c, tr_ctl[c], e_ctl[c]); n_err++;
            end
        end
        for (int c = 1; c <= 4; c++) begin
            n_vec++;
            if (tr_addr[c] !== AW'(32'h100 + c - 1)) begin
                $display("FAIL load_word_addr c%0d got %h want %h", c, tr_addr[c], 32'h100 + c - 1); n_err++;
            end
        end
        for (int c = 5; c <= 6; c++) begin
            n_vec++;
            if (tr_data[c] !== 32'h4433_2211) begin
                $display("FAIL load_word_data c%0d got %h want 44332211", c, tr_data[c]); n_err++;
            end
        end
    endtask

    task automatic test_load_half();
        logic [3:0] e_ctl [0:4] = '{4'b1000, 4'b1010, 4'b1010, 4'b0100, 4'b0000};
        issue(1'b0, 32'h300, 4'b1100, 32'h0, 5);
        for (int c = 0; c < 5; c++) begin
            n_vec++;
            if (tr_ctl[c] !== e_ctl[c]) begin
                $display("FAIL load_half_ctl c%0d got %b want %b", c, tr_ctl[c], e_ctl[c]); n_err++;
            end
        end
        n_vec++;
        if (tr_data[1] !== 32'h0) begin
            $display("FAIL load_half_clear got %h want 00000000", tr_data[1]); n_err++;
        end
        n_vec++;
        if (tr_addr[1] !== AW'(32'h302) || tr_addr[2] !== AW'(32'h303)) begin
            $display("FAIL load_half_addr got %h,%h want 302,303", tr_addr[1], tr_addr[2]); n_err++;
        end
        n_vec++;
        if (tr_data[3] !== 32'hFF80_0000 || tr_data[4] !== 32'hFF80_0000) begin
            $display("FAIL load_half_data got %h,%h want ff800000", tr_data[3], tr_data[4]); n_err++;
        end
    endtask

    task automatic test_sparse();
        logic [3:0] e_ctl [0:4] = '{4'b1000, 4'b1010, 4'b1010, 4'b0100, 4'b0000};
        issue(1'b0, 32'h100, 4'b0101, 32'h0, 5);
        for (int c = 0; c < 5; c++) begin
            n_vec++;
            if (tr_ctl[c] !== e_ctl[c]) begin
                $display("FAIL sparse_ctl c%0d got %b want %b", c, tr_ctl[c], e_ctl[c]); n_err++;
            end
        end
        n_vec++;
        if (tr_addr[1] !== AW'(32'h100) || tr_addr[2] !== AW'(32'h102)) begin
            $display("FAIL sparse_addr got %h,%h want 100,102", tr_addr[1], tr_addr[2]); n_err++;
        end
        n_vec++;
        if (tr_data[3] !== 32'h0033_0011) begin
            $display("FAIL sparse_data got %h want 00330011", tr_data[3]); n_err++;
        end
    endtask

    task automatic test_store_byte();
        logic [3:0] e_ctl [0:3] = '{4'b1000, 4'b1001, 4'b0100, 4'b0000};
        issue(1'b1, 32'h203, 4'b1000, 32'hA5A5_A5A5, 4);
        for (int c = 0; c < 4; c++) begin
            n_vec++;
            if (tr_ctl[c] !== e_ctl[c]) begin
                $display("FAIL store_byte_ctl c%0d got %b want %b", c, tr_ctl[c], e_ctl[c]); n_err++;
            end
        end
        n_vec++;
        if (tr_addr[1] !== AW'(32'h203) || tr_wd[1] !== 8'hA5) begin
            $display("FAIL store_byte_bus got addr=%h wd=%h want 203/a5", tr_addr[1], tr_wd[1]); n_err++;
        end
        n_vec++;
        if ({mem[32'h200], mem[32'h201], mem[32'h202], mem[32'h203]} !== 32'h1122_33A5) begin
            $display("FAIL store_byte_ram got %h%h%h%h want 112233a5",
                     mem[32'h200], mem[32'h201], mem[32'h202], mem[32'h203]); n_err++;
        end
    endtask

    task automatic test_sel_zero();
        ce = 1'b1; we = 1'b0; addr = 32'h100; sel = 4'b0000; wdata32 = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_vec++;
            if ({stall, done, r_re, r_we} !== 4'b0000) begin
                $display("FAIL sel_zero_ctl c%0d got %b want 0000", c, {stall, done, r_re, r_we}); n_err++;
            end
            @(posedge clk); #1;
        end
        ce = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [3:0] e_ctl [0:5] = '{4'b1000, 4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b0100};
        logic [7:0] e_wd  [0:3] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        ce = 1'b1; we = 1'b1; addr = 32'h500; sel = 4'hF; wdata32 = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #2;
        n_vec++;
        if ({stall, done, r_re, r_we} !== 4'b0000 || r_addr !== '0 || r_wd !== 8'h0 || d_out !== 32'h0) begin
            $display("FAIL reset_mid_out got ctl=%b addr=%h wd=%h data=%h want zeros",
                     {stall, done, r_re, r_we}, r_addr, r_wd, d_out); n_err++;
        end
        @(posedge clk); #1;
        n_vec++;
        if ({mem[32'h500], mem[32'h501], mem[32'h502], mem[32'h503]} !== 32'hEFBE_0000) begin
            $display("FAIL reset_mid_ram got %h%h%h%h want efbe0000",
                     mem[32'h500], mem[32'h501], mem[32'h502], mem[32'h503]); n_err++;
        end
        rst = 1'b0;
        issue(1'b1, 32'h500, 4'hF, 32'hDEAD_BEEF, 6);
        for (int c = 0; c < 6; c++) begin
            n_vec++;
            if (tr_ctl[c] !== e_ctl[c]) begin
                $display("FAIL retry_ctl c%0d got %b want %b", c, tr_ctl[c], e_ctl[c]); n_err++;
            end
        end
        for (int c = 1; c <= 4; c++) begin
            n_vec++;
            if (tr_addr[c] !== AW'(32'h500 + c - 1) || tr_wd[c] !== e_wd[c-1]) begin
                $display("FAIL retry_bus c%0d got %h/%h want %h/%h", c, tr_addr[c], tr_wd[c],
                         32'h500 + c - 1, e_wd[c-1]); n_err++;
            end
        end
        n_vec++;
        if ({mem[32'h503], mem[32'h502], mem[32'h501], mem[32'h500]} !== 32'hDEAD_BEEF) begin
            $display("FAIL retry_ram got %h%h%h%h want deadbeef",
                     mem[32'h503], mem[32'h502], mem[32'h501], mem[32'h500]); n_err++;
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] e_ld [0:6] = '{4'b1000, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b0100, 4'b0000};
        issue(1'b1, 32'h40, 4'hF, 32'h0A0B_0C0D, 6);
        n_vec++;
        if (tr_ctl[5] !== 4'b0100) begin
            $display("FAIL b2b_store_done got %b want 0100", tr_ctl[5]); n_err++;
        end
        issue(1'b0, 32'h40, 4'hF, 32'h0, 7);
        for (int c = 0; c < 7; c++) begin
            n_vec++;
            if (tr_ctl[c] !== e_ld[c]) begin
                $display("FAIL b2b_load_ctl c%0d got %b want %b", c, tr_ctl[c], e_ld[c]); n_err++;
            end
        end
        n_vec++;
        if (tr_data[5] !== 32'h0A0B_0C0D) begin
            $display("FAIL b2b_load_data got %h want 0a0b0c0d", tr_data[5]); n_err++;
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
        mem[32'h100] = 8'h11; mem[32'h101] = 8'h22; mem[32'h102] = 8'h33; mem[32'h103] = 8'h44;
        mem[32'h302] = 8'h80; mem[32'h303] = 8'hFF;
        mem[32'h200] = 8'h11; mem[32'h201] = 8'h22; mem[32'h202] = 8'h33;
        r_rd = 8'h00;

        test_reset();
        test_load_word();
        test_load_half();
        test_sparse();
        test_store_byte();
        test_sel_zero();
        test_reset_mid();
        test_back_to_back();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
